// File: rtl/load_store_unit.sv
// Multicycle RV64 load/store engine on a doubleword-wide data memory; partial stores do read-modify-write.
// Latency after accept: fault 1, sd 2, load L+1, partial store L+2 cycles. start is ignored while busy.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [63:0] rdata,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t      state_q;
  logic [63:0] line_q;
  logic [63:0] wdat_q;
  logic [63:0] wbuf_q;
  logic [63:0] rdata_q;
  logic [2:0]  off_q;
  logic [2:0]  f3_q;
  logic [2:0]  cnt_q;
  logic        st_q;
  logic        fault_q;
  logic        busy_q;
  logic        done_q;
  logic        mem_wr_q;

  logic        acc_fault;
  logic [63:0] shifted;
  logic [63:0] rdata_d;
  logic [7:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wmask;
  logic [63:0] wshift;
  logic [63:0] wbuf_d;

  // Fault check works on the raw request so a bad access never leaves IDLE for RD/WR.
  always_comb begin
    acc_fault = 1'b0;
    if (!is_store && funct3 == 3'b111) acc_fault = 1'b1;
    if (is_store && funct3[2])         acc_fault = 1'b1;
    case (funct3[1:0])
      2'b01:   if (addr[0])             acc_fault = 1'b1;
      2'b10:   if (addr[1:0] != 2'b00)  acc_fault = 1'b1;
      2'b11:   if (addr[2:0] != 3'b000) acc_fault = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  rdata_d = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  rdata_d = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  rdata_d = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  rdata_d = {56'd0, shifted[7:0]};
      3'b101:  rdata_d = {48'd0, shifted[15:0]};
      3'b110:  rdata_d = {32'd0, shifted[31:0]};
      default: rdata_d = shifted;
    endcase
  end

  // Byte-enable mask of the addressed lanes, expanded to bits for the merge.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    lane_mask = size_mask << off_q;
    wmask = '0;
    for (int i = 0; i < 8; i++) begin
      wmask[8*i +: 8] = {8{lane_mask[i]}};
    end
    wshift = wdat_q << {off_q, 3'b000};
    wbuf_d = (mem_rdata & ~wmask) | (wshift & wmask);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      line_q   <= '0;
      wdat_q   <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      cnt_q    <= '0;
      st_q     <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            line_q  <= {addr[63:3], 3'b000};
            off_q   <= addr[2:0];
            f3_q    <= funct3;
            st_q    <= is_store;
            wdat_q  <= wdata;
            fault_q <= acc_fault;
            busy_q  <= 1'b1;
            if (acc_fault) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (is_store && funct3[1:0] == 2'b11) begin
              wbuf_q   <= wdata;
              state_q  <= WR;
              mem_wr_q <= 1'b1;
            end else begin
              cnt_q   <= LAT;
              state_q <= RD;
            end
          end
        end
        RD: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (st_q) begin
              wbuf_q   <= wbuf_d;
              state_q  <= WR;
              mem_wr_q <= 1'b1;
            end else begin
              rdata_q <= rdata_d;
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_raddr = line_q;
  assign mem_waddr = line_q;
  assign mem_wdata = wbuf_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MEM_LATENCY=1 and a 16-line combinational-read memory.
// Expected outcomes are queued before each request and compared when done is seen.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [63:0] rdata;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  logic        preload;
  logic [63:0] mem [0:15];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          done_cyc;
    int          wr_cyc;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
  } exp_t;

  exp_t sb_q[$];

  load_store_unit #(.MEM_LATENCY(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_raddr[6:3]];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
      mem[8] <= 64'h8877665544332211;
    end else if (mem_wr) begin
      mem[mem_waddr[6:3]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void push_exp(input logic [63:0] r, input logic f, input int dc,
                                   input int wc, input logic [63:0] wa, input logic [63:0] wd);
    exp_t e;
    e.rdata = r; e.fault = f; e.done_cyc = dc;
    e.wr_cyc = wc; e.wr_addr = wa; e.wr_data = wd;
    sb_q.push_back(e);
  endfunction

  // Issue one request at the next edge, follow it to done, then score it against the queue head.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input bit hold);
    exp_t        e;
    int          n;
    int          wr_n;
    int          wr_at;
    logic [63:0] wr_a;
    logic [63:0] wr_d;
    logic        busy_ok;
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    n = 1; wr_n = 0; wr_at = 0; wr_a = '0; wr_d = '0; busy_ok = 1'b1;
    while (!done && n < 16) begin
      if (!busy) busy_ok = 1'b0;
      if (mem_wr) begin
        wr_n++; wr_at = n; wr_a = mem_waddr; wr_d = mem_wdata;
      end
      @(posedge clock); #1;
      n++;
    end
    check({tag, ".done_seen"}, 64'(done), 64'd1);
    e = sb_q.pop_front();
    check({tag, ".done_cycle"}, 64'(n), 64'(e.done_cyc));
    check({tag, ".busy"}, 64'(busy_ok & busy), 64'd1);
    check({tag, ".fault"}, 64'(fault), 64'(e.fault));
    check({tag, ".rdata"}, rdata, e.rdata);
    check({tag, ".wr_count"}, 64'(wr_n), (e.wr_cyc != 0) ? 64'd1 : 64'd0);
    if (e.wr_cyc != 0) begin
      check({tag, ".wr_cycle"}, 64'(wr_at), 64'(e.wr_cyc));
      check({tag, ".wr_addr"}, wr_a, e.wr_addr);
      check({tag, ".wr_data"}, wr_d, e.wr_data);
    end
    @(posedge clock); #1;
    check({tag, ".idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; preload = 1'b1; start = 1'b0;
    is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.fault", 64'(fault), 64'd0);
    check("reset.rdata", rdata, 64'd0);
    check("reset.mem_wr", 64'(mem_wr), 64'd0);
    check("reset.mem_raddr", mem_raddr, 64'd0);
    check("reset.mem_waddr", mem_waddr, 64'd0);
    check("reset.mem_wdata", mem_wdata, 64'd0);
    preload = 1'b0; reset = 1'b1;
    @(posedge clock); #1;

    push_exp(64'hFFFFFFFFFFFFFF88, 1'b0, 2, 0, 0, 0);
    run_op("lb47", 1'b0, 3'b000, 64'h47, 64'd0, 1'b0);
    push_exp(64'h0000000000000088, 1'b0, 2, 0, 0, 0);
    run_op("lbu47", 1'b0, 3'b100, 64'h47, 64'd0, 1'b0);
    push_exp(64'h0000000000004433, 1'b0, 2, 0, 0, 0);
    run_op("lh42", 1'b0, 3'b001, 64'h42, 64'd0, 1'b0);
    push_exp(64'hFFFFFFFF88776655, 1'b0, 2, 0, 0, 0);
    run_op("lw44", 1'b0, 3'b010, 64'h44, 64'd0, 1'b0);
    push_exp(64'h0000000088776655, 1'b0, 2, 0, 0, 0);
    run_op("lwu44", 1'b0, 3'b110, 64'h44, 64'd0, 1'b0);
    push_exp(64'h8877665544332211, 1'b0, 2, 0, 0, 0);
    run_op("ld40", 1'b0, 3'b011, 64'h40, 64'd0, 1'b0);

    push_exp(64'h8877665544332211, 1'b0, 3, 2, 64'h40, 64'h887766554433AB11);
    run_op("sb41", 1'b1, 3'b000, 64'h41, 64'h000000000000CDAB, 1'b0);
    push_exp(64'h887766554433AB11, 1'b0, 2, 0, 0, 0);
    run_op("ld40_after_sb", 1'b0, 3'b011, 64'h40, 64'd0, 1'b0);

    push_exp(64'h887766554433AB11, 1'b0, 2, 1, 64'h48, 64'h0123456789ABCDEF);
    run_op("sd48", 1'b1, 3'b011, 64'h48, 64'h0123456789ABCDEF, 1'b0);
    check("sd48.mem_line", mem[9], 64'h0123456789ABCDEF);
    push_exp(64'h0123456789ABCDEF, 1'b0, 2, 0, 0, 0);
    run_op("ld48", 1'b0, 3'b011, 64'h48, 64'd0, 1'b0);
    push_exp(64'hFFFFFFFFFFFF8877, 1'b0, 2, 0, 0, 0);
    run_op("lh46", 1'b0, 3'b001, 64'h46, 64'd0, 1'b0);

    push_exp(64'hFFFFFFFFFFFF8877, 1'b1, 1, 0, 0, 0);
    run_op("lw42_misaligned", 1'b0, 3'b010, 64'h42, 64'd0, 1'b0);
    push_exp(64'hFFFFFFFFFFFF8877, 1'b1, 1, 0, 0, 0);
    run_op("load_f3_111", 1'b0, 3'b111, 64'h40, 64'd0, 1'b0);
    push_exp(64'hFFFFFFFFFFFF8877, 1'b1, 1, 0, 0, 0);
    run_op("store_f3_100", 1'b1, 3'b100, 64'h40, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_exp(64'hFFFFFFFFFFFF8877, 1'b1, 1, 0, 0, 0);
    run_op("sh41_misaligned", 1'b1, 3'b001, 64'h41, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    check("faults.mem_line", mem[8], 64'h887766554433AB11);

    // start held high: the first sb completes alone, the retained start is taken the cycle after done
    push_exp(64'hFFFFFFFFFFFF8877, 1'b0, 3, 2, 64'h40, 64'h887766554433AB55);
    run_op("sb40_held", 1'b1, 3'b000, 64'h40, 64'h0000000000000055, 1'b1);
    @(posedge clock); #1;
    check("held.reaccept_busy", 64'(busy), 64'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 16) begin
      @(posedge clock); #1;
      n++;
    end
    check("held.second_done", 64'(done), 64'd1);
    @(posedge clock); #1;
    check("held.mem_line", mem[8], 64'h887766554433AB55);

    is_store = 1'b1; funct3 = 3'b011; addr = 64'h48; wdata = 64'hDEADBEEFDEADBEEF; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("rst_wr.mem_wr_before", 64'(mem_wr), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_wr.mem_wr", 64'(mem_wr), 64'd0);
    check("rst_wr.busy", 64'(busy), 64'd0);
    check("rst_wr.rdata", rdata, 64'd0);
    check("rst_wr.mem_waddr", mem_waddr, 64'd0);
    check("rst_wr.mem_wdata", mem_wdata, 64'd0);
    @(posedge clock); #1;
    check("rst_wr.mem_line", mem[9], 64'h0123456789ABCDEF);
    reset = 1'b1;
    @(posedge clock); #1;
    push_exp(64'h0123456789ABCDEF, 1'b0, 2, 0, 0, 0);
    run_op("ld48_after_reset", 1'b0, 3'b011, 64'h48, 64'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
